// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter: N ready/valid requesters into one registered ready/valid output stage.
// Optional checks are compiled in with HANDSHAKE_RR_ARBITER_ASSERT_EN.
module handshake_rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int N     = 3,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESETN,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_src
);

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SW-1:0]     r_out_src;
    logic [SW-1:0]     r_last;

    logic              w_found;
    logic [SW-1:0]     w_gnt_idx;
    logic [SW-1:0]     w_cand;
    logic              w_can_load;
    logic              w_load;
    logic [WIDTH-1:0]  w_payload;

    // Search starts just after the most recent grant and wraps modulo N.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = SW'((int'(r_last) + k) % N);
            if (!w_found && in_valid[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    assign w_can_load = !r_out_valid || out_ready;
    assign w_load     = w_found && w_can_load;

    always_comb begin
        in_ready  = '0;
        w_payload = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = ASYNCRESETN && w_load && (w_gnt_idx == SW'(i));
            if (w_gnt_idx == SW'(i))
                w_payload = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_last      <= SW'(N - 1);
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_payload;
            r_out_src   <= w_gnt_idx;
            r_last      <= w_gnt_idx;
        end else if (out_ready) begin
            // Drain with nothing to reload: payload and source are kept.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

`ifdef HANDSHAKE_RR_ARBITER_ASSERT_EN
    logic [31:0] r_cyc;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN)
            r_cyc <= '0;
        else
            r_cyc <= r_cyc + 32'd1;
    end

    a_ready_onehot: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        $onehot0(in_ready))
        else $error("in_ready %b not one-hot-or-zero at cycle %0d", in_ready, r_cyc);

    a_out_hold: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        out_valid && !out_ready |=> out_valid && $stable(out_data) && $stable(out_src))
        else $error("output beat from src %0d not held under stall at cycle %0d", out_src, r_cyc);

    for (genvar gi = 0; gi < N; gi++) begin : g_req_chk
        a_ready_needs_valid: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
            in_ready[gi] |-> in_valid[gi])
            else $error("in_ready[%0d] without in_valid at cycle %0d", gi, r_cyc);

        a_req_hold: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
            in_valid[gi] && !in_ready[gi] |=> in_valid[gi] && $stable(in_data[gi*WIDTH +: WIDTH]))
            else $error("requester %0d withdrew or changed a pending beat at cycle %0d", gi, r_cyc);
    end
`else
    // No checks compiled in this build.
`endif

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Bench for handshake_rr_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a behavioural round-robin model.
module tb_handshake_rr_arbiter;

    localparam int WIDTH = 4;
    localparam int N     = 3;
    localparam int SW    = 2;

    logic                CLK;
    logic                ASYNCRESETN;
    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_ready;
    logic [N*WIDTH-1:0]  in_data;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [SW-1:0]       out_src;

    handshake_rr_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
        .CLK        (CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: what the output stage must hold and who was granted last.
    bit          m_vld  = 0;
    int          m_data = 0;
    int          m_src  = 0;
    int          m_last = N - 1;
    bit [N-1:0]  m_acc  = '0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Compare outputs to the model every cycle, then advance the model with the
    // inputs that will be seen at the coming rising edge.
    always @(negedge CLK) begin
        int          g;
        bit          can;
        bit [N-1:0]  exp_rdy;
        logic [N*WIDTH-1:0] sh;
        if (!ASYNCRESETN) begin
            m_vld  = 0;
            m_data = 0;
            m_src  = 0;
            m_last = N - 1;
            m_acc  = '0;
            check("rst_in_ready", int'(in_ready), 0);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_data", int'(out_data), 0);
            check("rst_out_src", int'(out_src), 0);
        end else begin
            g = -1;
            for (int k = 1; k <= N; k++)
                if (g < 0 && in_valid[(m_last + k) % N]) g = (m_last + k) % N;
            can     = !m_vld || out_ready;
            exp_rdy = (g >= 0 && can) ? (N'(1) << g) : '0;
            check("in_ready", int'(in_ready), int'(exp_rdy));
            check("out_valid", int'(out_valid), int'(m_vld));
            check("out_data", int'(out_data), m_data);
            check("out_src", int'(out_src), m_src);
            if (exp_rdy != '0) begin
                sh     = in_data >> (g * WIDTH);
                m_vld  = 1;
                m_data = int'(sh[WIDTH-1:0]);
                m_src  = g;
                m_last = g;
            end else if (m_vld && out_ready) begin
                m_vld = 0;
            end
            m_acc = exp_rdy;
        end
    end

    task automatic do_reset();
        @(posedge CLK);
        #1;
        ASYNCRESETN = 1'b0;
        in_valid    = '0;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        ASYNCRESETN = 1'b1;
    endtask

    initial begin
        ASYNCRESETN = 1'b0;
        in_valid    = '0;
        in_data     = '0;
        out_ready   = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        ASYNCRESETN = 1'b1;

        // Idle after reset
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_in_ready", int'(in_ready), 0);
        check("idle_out_data", int'(out_data), 0);

        // Single requester 1 with payload A
        @(posedge CLK);
        #1;
        in_valid  = 3'b010;
        in_data   = 12'h0A0;
        out_ready = 1'b1;
        @(negedge CLK);
        check("single_ready0", int'(in_ready), 2);
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("single_ready", int'(in_ready), 2);
            check("single_valid", int'(out_valid), 1);
            check("single_data", int'(out_data), 10);
            check("single_src", int'(out_src), 1);
        end
        @(posedge CLK);
        #1;
        in_valid = '0;

        // All valid: strict rotation without bubbles
        do_reset();
        in_valid  = 3'b111;
        in_data   = {4'h3, 4'h2, 4'h1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("rot_valid", int'(out_valid), 1);
            check("rot_src", int'(out_src), i % 3);
            check("rot_data", int'(out_data), (i % 3) + 1);
        end

        // Backpressure for three cycles, then resume
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("bp_ready", int'(in_ready), 0);
            check("bp_valid", int'(out_valid), 1);
            check("bp_src", int'(out_src), 0);
            check("bp_data", int'(out_data), 1);
            @(posedge CLK);
        end
        #1;
        out_ready = 1'b1;
        @(negedge CLK);
        check("resume_ready", int'(in_ready), 2);
        @(posedge CLK);
        @(negedge CLK);
        check("resume_src", int'(out_src), 1);
        check("resume_data", int'(out_data), 2);

        // Drain only: beat from requester 2, nothing behind it
        do_reset();
        in_valid  = 3'b100;
        in_data   = 12'h700;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = '0;
        @(negedge CLK);
        check("drain_valid0", int'(out_valid), 1);
        check("drain_src0", int'(out_src), 2);
        @(posedge CLK);
        @(negedge CLK);
        check("drain_valid1", int'(out_valid), 0);
        check("drain_src1", int'(out_src), 2);
        check("drain_data1", int'(out_data), 7);

        // Reset while a beat is held
        @(posedge CLK);
        #1;
        in_valid = 3'b111;
        in_data  = {4'h3, 4'h2, 4'h1};
        @(posedge CLK);
        @(posedge CLK);
        #3;
        check("pre_rst_valid", int'(out_valid), 1);
        ASYNCRESETN = 1'b0;
        #1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_ready", int'(in_ready), 0);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        ASYNCRESETN = 1'b1;
        @(negedge CLK);
        check("postrst_ready", int'(in_ready), 1);
        @(posedge CLK);
        @(negedge CLK);
        check("postrst_src", int'(out_src), 0);
        check("postrst_valid", int'(out_valid), 1);

        // Randomized traffic obeying the hold-until-accepted rule
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || m_acc[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        in_valid[i]              = 1'b1;
                        in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                    end else begin
                        in_valid[i] = 1'b0;
                    end
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge CLK);
        @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
